k10_trace_ctrl: RTL and testbench
=================================

K10_TRACE_CTRL -- requirements
Module: k10_trace_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning record FIFO entries (power of 2, >= 4).
REQ-002 SHALL have parameter FULL_TRACE_N, default 200, meaning the first N retirements are recorded unfiltered.
REQ-003 SHALL have port i_clk input 1, the clock; reset i_rst_n input 1, synchronous, active-low.
REQ-004 SHALL have ports i_enable input 1 (trace enable) and i_clr_stats input 1 (clear drop statistics).
REQ-005 SHALL have WB commit ports i_valid 1, i_pc 32, i_instr 32, i_rd_addr 5, i_rd_data 32, i_rd_wr_en 1, i_mode 2 (priv_lvl_e encoding), all inputs.
REQ-006 SHALL have record stream outputs o_rec_valid 1, o_rec_pc 32, o_rec_instr 32, o_rec_rd_addr 5, o_rec_rd_data 32, o_rec_has_gpr 1, o_rec_mode 2, o_rec_seq 32, plus input i_rec_ready 1.
REQ-007 SHALL have status outputs o_stall_req 1 (backpressure to core), o_drop_cnt 16 (dropped records), o_overflow 1 (sticky drop flag), o_busy 1 (state != IDLE).

Function
REQ-008 SHALL implement FSM states IDLE, RUN, DRAIN.
REQ-009 IDLE->RUN SHALL occur on the cycle after i_enable=1 is sampled; on this transition the retirement counter SHALL clear to 0.
REQ-010 RUN->DRAIN SHALL occur on the cycle after i_enable=0 is sampled; DRAIN->IDLE SHALL occur once the FIFO is empty; DRAIN->RUN SHALL occur if i_enable=1 is sampled, without clearing the counter.
REQ-011 Commits SHALL be captured only in RUN; i_valid in IDLE or DRAIN is ignored and not counted.
REQ-012 In RUN each i_valid SHALL increment a 32-bit retirement counter, which wraps from 0xFFFFFFFF to 0; the record's seq SHALL equal the post-increment value, making the first retirement seq=1.
REQ-013 A commit SHALL be recorded iff pre-increment count < FULL_TRACE_N, or (i_rd_wr_en=1 and i_rd_addr!=0).
REQ-014 has_gpr SHALL be i_rd_wr_en && (i_rd_addr!=0); when has_gpr=0, stored rd_addr and rd_data SHALL be zero.
REQ-015 A recorded commit SHALL be written into the FIFO in the same cycle; head record SHALL appear on outputs the next cycle (push-to-valid latency 1).
REQ-016 o_rec_valid SHALL equal FIFO non-empty; a pop occurs when o_rec_valid && i_rec_ready; o_rec_* SHALL hold stable while valid && !ready.
REQ-017 When the FIFO is full and no pop occurs that cycle, a recorded commit SHALL be dropped; o_drop_cnt increments, saturating at 0xFFFF; o_overflow sets.
REQ-018 When the FIFO is full and a pop occurs in the same cycle, the push SHALL be accepted with no drop.
REQ-019 o_stall_req SHALL be a register set when the post-update occupancy >= DEPTH-2, and cleared otherwise.
REQ-020 i_clr_stats SHALL zero o_drop_cnt and o_overflow next cycle; a simultaneous drop SHALL take priority and yield drop_cnt=1 and overflow=1.
REQ-021 Non-recorded commits SHALL still increment the retirement counter, so seq gaps are legal.

Reset
REQ-022 With i_rst_n=0 at a clock edge, the block SHALL enter IDLE, empty the FIFO, clear the counter, and drive all outputs to 0, including o_rec_valid.
REQ-023 Reset mid-DRAIN or mid-RUN SHALL discard all buffered records, with no partial record emitted afterwards.

Verification
REQ-024 enable=1, 3 commits (rd=x5 data 0x11, a store, rd=x0), ready=1 -> 3 records, seq 1,2,3, has_gpr 1,0,0, rd_addr 5,0,0.
REQ-025 FULL_TRACE_N=2, 4 commits alternating GPR write and store -> records seq 1,2,3 only; the store at seq 4 is filtered.
REQ-026 DEPTH=8, ready=0, 10 GPR-writing commits -> 8 buffered, o_drop_cnt=2, o_overflow=1, o_stall_req high from occupancy 6; then i_clr_stats -> 0/0.
REQ-027 FIFO full, ready=1 and a GPR commit in the same cycle -> no drop, occupancy stays 8.
REQ-028 5 records buffered, enable=0, ready=1 -> o_busy high through DRAIN; 5 records emitted; IDLE reached after the last pop; commits during DRAIN are ignored.
REQ-029 Reset asserted with 4 buffered records -> next cycle o_rec_valid=0, o_busy=0, o_drop_cnt=0; re-enable yields seq=1.

Source files
------------

// File: rtl/k10_trace_ctrl.sv
// k10_trace_ctrl: captures WB-stage retirements into a record FIFO. The first
// FULL_TRACE_N retirements are kept unfiltered; after that only GPR writes are kept.
module k10_trace_ctrl #(
   parameter int DEPTH        = 8,
   parameter int FULL_TRACE_N = 200
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_enable,
   input  logic        i_clr_stats,
   input  logic        i_valid,
   input  logic [31:0] i_pc,
   input  logic [31:0] i_instr,
   input  logic [4:0]  i_rd_addr,
   input  logic [31:0] i_rd_data,
   input  logic        i_rd_wr_en,
   input  logic [1:0]  i_mode,
   output logic        o_rec_valid,
   output logic [31:0] o_rec_pc,
   output logic [31:0] o_rec_instr,
   output logic [4:0]  o_rec_rd_addr,
   output logic [31:0] o_rec_rd_data,
   output logic        o_rec_has_gpr,
   output logic [1:0]  o_rec_mode,
   output logic [31:0] o_rec_seq,
   input  logic        i_rec_ready,
   output logic        o_stall_req,
   output logic [15:0] o_drop_cnt,
   output logic        o_overflow,
   output logic        o_busy
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LVL  = (AW+1)'(DEPTH);
   localparam logic [AW:0] STALL_LVL = (AW+1)'(DEPTH - 2);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [4:0]  rd_addr;
      logic [31:0] rd_data;
      logic        has_gpr;
      logic [1:0]  mode;
      logic [31:0] seq;
   } rec_t;

   state_e        state, state_nxt;
   logic          clr_retire;
   rec_t          mem [DEPTH];
   rec_t          rec_in, head;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count, count_nxt;
   logic [31:0]   retire_cnt, seq_nxt;
   logic          capture, has_gpr, record, pop, push, drop;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      clr_retire = 1'b0;
      unique case (state)
         IDLE: begin
            if (i_enable) begin
               state_nxt  = RUN;
               clr_retire = 1'b1;
            end
         end
         RUN: begin
            if (!i_enable) state_nxt = DRAIN;
         end
         DRAIN: begin
            if (i_enable)           state_nxt = RUN;
            else if (count == '0)   state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Filter decision uses the pre-increment count; seq carries the post-increment value.
   assign capture   = (state == RUN) && i_valid;
   assign has_gpr   = i_rd_wr_en && (i_rd_addr != 5'd0);
   assign seq_nxt   = retire_cnt + 32'd1;
   assign record    = capture && ((retire_cnt < 32'(FULL_TRACE_N)) || has_gpr);
   assign pop       = o_rec_valid && i_rec_ready;
   assign push      = record && ((count != FULL_LVL) || pop);
   assign drop      = record && (count == FULL_LVL) && !pop;
   assign count_nxt = count + (AW+1)'(push) - (AW+1)'(pop);

   always_comb begin
      rec_in         = '0;
      rec_in.pc      = i_pc;
      rec_in.instr   = i_instr;
      rec_in.has_gpr = has_gpr;
      rec_in.rd_addr = has_gpr ? i_rd_addr : 5'd0;
      rec_in.rd_data = has_gpr ? i_rd_data : 32'd0;
      rec_in.mode    = i_mode;
      rec_in.seq     = seq_nxt;
   end

   always_ff @(posedge i_clk) begin
      if (push) mem[wr_ptr] <= rec_in;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         retire_cnt  <= '0;
         o_stall_req <= 1'b0;
         o_drop_cnt  <= '0;
         o_overflow  <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         count       <= count_nxt;
         o_stall_req <= (count_nxt >= STALL_LVL);
         if (clr_retire)   retire_cnt <= '0;
         else if (capture) retire_cnt <= seq_nxt;
         if (drop) begin
            o_drop_cnt <= i_clr_stats ? 16'd1 : sat_inc16(o_drop_cnt);
            o_overflow <= 1'b1;
         end else if (i_clr_stats) begin
            o_drop_cnt <= '0;
            o_overflow <= 1'b0;
         end
      end
   end

   // Head is masked while empty so stale storage never reaches the outputs.
   assign o_rec_valid   = (count != '0);
   assign head          = o_rec_valid ? mem[rd_ptr] : '0;
   assign o_rec_pc      = head.pc;
   assign o_rec_instr   = head.instr;
   assign o_rec_rd_addr = head.rd_addr;
   assign o_rec_rd_data = head.rd_data;
   assign o_rec_has_gpr = head.has_gpr;
   assign o_rec_mode    = head.mode;
   assign o_rec_seq     = head.seq;
   assign o_busy        = (state != IDLE);

endmodule

// File: tb/tb_k10_trace_ctrl.sv
// Bench for k10_trace_ctrl: directed scenarios plus random traffic, all checked
// cycle by cycle against a queue-based model of the trace rules.
module tb_k10_trace_ctrl;
   localparam int DEPTH = 8;
   localparam int FTN   = 200;

   logic        clk = 1'b0;
   logic        rst_n, enable, clr_stats, valid, rd_wr_en, rec_ready;
   logic [31:0] pc, instr, rd_data;
   logic [4:0]  rd_addr;
   logic [1:0]  mode;
   logic        rec_valid, rec_has_gpr, stall_req, overflow, busy;
   logic [31:0] rec_pc, rec_instr, rec_rd_data, rec_seq;
   logic [4:0]  rec_rd_addr;
   logic [1:0]  rec_mode;
   logic [15:0] drop_cnt;

   k10_trace_ctrl #(.DEPTH(DEPTH), .FULL_TRACE_N(FTN)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_clr_stats(clr_stats),
      .i_valid(valid), .i_pc(pc), .i_instr(instr), .i_rd_addr(rd_addr),
      .i_rd_data(rd_data), .i_rd_wr_en(rd_wr_en), .i_mode(mode),
      .o_rec_valid(rec_valid), .o_rec_pc(rec_pc), .o_rec_instr(rec_instr),
      .o_rec_rd_addr(rec_rd_addr), .o_rec_rd_data(rec_rd_data),
      .o_rec_has_gpr(rec_has_gpr), .o_rec_mode(rec_mode), .o_rec_seq(rec_seq),
      .i_rec_ready(rec_ready), .o_stall_req(stall_req), .o_drop_cnt(drop_cnt),
      .o_overflow(overflow), .o_busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc, instr;
      logic [4:0]  rd;
      logic [31:0] data;
      logic        gpr;
      logic [1:0]  mode;
      logic [31:0] seq;
   } rec_s;

   rec_s        q[$];
   bit          m_run, m_drain, m_ovf, m_stall;
   logic [31:0] m_ret;
   int          m_drops;
   int          vectors = 0;
   int          miscompares = 0;
   string       phase = "reset";

   // Reference model: advances by one clock using the inputs about to be sampled.
   task automatic model_step();
      bit pop, rec, drop, was_empty;
      rec_s r;
      logic [31:0] pre;
      if (!rst_n) begin
         q.delete();
         m_run = 0; m_drain = 0; m_ret = 0; m_drops = 0; m_ovf = 0; m_stall = 0;
         return;
      end
      was_empty = (q.size() == 0);
      pop = !was_empty && rec_ready;
      rec = 0;
      drop = 0;
      if (m_run && valid) begin
         pre    = m_ret;
         m_ret  = m_ret + 32'd1;
         r.gpr  = rd_wr_en && (rd_addr != 5'd0);
         r.pc   = pc;
         r.instr = instr;
         r.rd   = r.gpr ? rd_addr : 5'd0;
         r.data = r.gpr ? rd_data : 32'd0;
         r.mode = mode;
         r.seq  = m_ret;
         rec    = (pre < FTN) || r.gpr;
      end
      if (pop) void'(q.pop_front());
      if (rec) begin
         if (q.size() < DEPTH) q.push_back(r);
         else drop = 1;
      end
      m_stall = (q.size() >= DEPTH - 2);
      if (drop) begin
         m_drops = clr_stats ? 1 : ((m_drops == 65535) ? 65535 : m_drops + 1);
         m_ovf = 1;
      end else if (clr_stats) begin
         m_drops = 0;
         m_ovf = 0;
      end
      if (!m_run && !m_drain) begin
         if (enable) begin m_run = 1; m_ret = 0; end
      end else if (m_run) begin
         if (!enable) begin m_run = 0; m_drain = 1; end
      end else begin
         if (enable) begin m_run = 1; m_drain = 0; end
         else if (was_empty) m_drain = 0;
      end
   endtask

   task automatic check_all();
      logic [136:0] g, e;
      logic [18:0]  gs, es;
      g = {rec_valid, rec_pc, rec_instr, rec_rd_addr, rec_rd_data, rec_has_gpr, rec_mode, rec_seq};
      if (q.size() > 0) e = {1'b1, q[0].pc, q[0].instr, q[0].rd, q[0].data, q[0].gpr, q[0].mode, q[0].seq};
      else e = '0;
      gs = {stall_req, drop_cnt, overflow, busy};
      es = {m_stall, 16'(m_drops), m_ovf, (m_run || m_drain)};
      vectors++;
      assert (g === e) else begin
         miscompares++;
         $error("FAIL %s record: got %h expected %h", phase, g, e);
      end
      vectors++;
      assert (gs === es) else begin
         miscompares++;
         $error("FAIL %s status{stall,drop,ovf,busy}: got %h expected %h", phase, gs, es);
      end
   endtask

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic commit(logic [4:0] rd, logic [31:0] data, logic we);
      valid    = 1'b1;
      pc       = $urandom;
      instr    = $urandom;
      rd_addr  = rd;
      rd_data  = data;
      rd_wr_en = we;
      mode     = 2'($urandom);
      tick();
      valid    = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: bench did not reach its end");
      $fatal(1, "timeout");
   end

   initial begin
      int pops, n;
      rst_n = 0; enable = 0; clr_stats = 0; valid = 0; rd_wr_en = 0; rec_ready = 0;
      pc = 0; instr = 0; rd_data = 0; rd_addr = 0; mode = 0;
      tick();
      tick();
      chk("reset rec_valid", rec_valid, 0);
      chk("reset busy", busy, 0);
      chk("reset drop_cnt", drop_cnt, 0);

      phase = "basic";
      rst_n = 1; enable = 1; rec_ready = 1;
      tick();
      commit(5'd5, 32'h11, 1'b1);
      chk("basic seq1", rec_seq, 1);
      chk("basic gpr1", rec_has_gpr, 1);
      chk("basic rd1", rec_rd_addr, 5);
      commit(5'd3, 32'hDEAD, 1'b0);
      chk("basic seq2", rec_seq, 2);
      chk("basic gpr2", rec_has_gpr, 0);
      chk("basic rd2", rec_rd_addr, 0);
      commit(5'd0, 32'hBEEF, 1'b1);
      chk("basic seq3", rec_seq, 3);
      chk("basic gpr3", rec_has_gpr, 0);
      chk("basic data3", rec_rd_data, 0);
      tick();

      phase = "overflow";
      rec_ready = 0;
      for (int i = 1; i <= 10; i++) begin
         commit(5'($urandom_range(1, 31)), $urandom, 1'b1);
         chk("stall vs occupancy", stall_req, (i >= 6) ? 1 : 0);
      end
      chk("ovf drop_cnt", drop_cnt, 2);
      chk("ovf flag", overflow, 1);

      phase = "full_pop_push";
      rec_ready = 1;
      commit(5'd7, $urandom, 1'b1);
      chk("full pop+push drop_cnt", drop_cnt, 2);
      chk("full pop+push stall", stall_req, 1);
      rec_ready = 0; clr_stats = 1;
      tick();
      chk("clr drop_cnt", drop_cnt, 0);
      chk("clr overflow", overflow, 0);
      commit(5'd9, $urandom, 1'b1);
      clr_stats = 0;
      chk("clr+drop drop_cnt", drop_cnt, 1);
      chk("clr+drop overflow", overflow, 1);

      phase = "drain";
      rec_ready = 1;
      for (int i = 0; i < 9; i++) tick();
      rec_ready = 0;
      for (int i = 0; i < 5; i++) commit(5'($urandom_range(1, 31)), $urandom, 1'b1);
      enable = 0; rec_ready = 1; valid = 0;
      pops = 0; n = 0;
      do begin
         pops += rec_valid ? 1 : 0;
         tick();
         valid = 1; rd_wr_en = 1; rd_addr = 5'd4; rd_data = $urandom; pc = $urandom;
         n++;
         if (busy) chk("drain busy", busy, 1);
      end while (busy && n < 20);
      valid = 0;
      chk("drain reached idle", busy, 0);
      chk("drain pops", pops, 5);

      phase = "reset_mid";
      enable = 1;
      tick();
      rec_ready = 0;
      for (int i = 0; i < 4; i++) commit(5'($urandom_range(1, 31)), $urandom, 1'b1);
      rst_n = 0;
      tick();
      chk("rst rec_valid", rec_valid, 0);
      chk("rst busy", busy, 0);
      chk("rst drop_cnt", drop_cnt, 0);
      rst_n = 1; rec_ready = 1;
      tick();
      commit(5'd2, 32'h5, 1'b1);
      chk("rst reenable seq", rec_seq, 1);

      phase = "filter";
      rst_n = 0;
      tick();
      rst_n = 1;
      tick();
      for (int i = 0; i < FTN; i++) commit(5'($urandom_range(1, 31)), $urandom, 1'b0);
      commit(5'd6, 32'h66, 1'b1);
      chk("filter gpr valid", rec_valid, 1);
      chk("filter gpr seq", rec_seq, FTN + 1);
      commit(5'd6, 32'h77, 1'b0);
      chk("filter store dropped", rec_valid, 0);
      commit(5'd8, 32'h88, 1'b1);
      chk("filter gpr seq gap", rec_seq, FTN + 3);

      phase = "random";
      for (int c = 0; c < 3000; c++) begin
         rst_n     = ($urandom_range(0, 499) != 0);
         enable    = ($urandom_range(0, 99) < 93);
         clr_stats = ($urandom_range(0, 99) < 3);
         rec_ready = ($urandom_range(0, 99) < 55);
         valid     = ($urandom_range(0, 99) < 75);
         pc        = $urandom;
         instr     = $urandom;
         rd_addr   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
         rd_data   = $urandom;
         rd_wr_en  = 1'($urandom_range(0, 1));
         mode      = 2'($urandom);
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
